// File: rtl/mram_spi_pkg.sv
// Shared definitions for the MRAM SPI frame generator.
// Contents: SPI opcodes, width of the address field on the wire, the frame
// FSM state encoding and a helper that gives the frame length in bits.
package mram_spi_pkg;

    localparam logic [7:0] OPC_READ       = 8'h03;
    localparam logic [7:0] OPC_WRITE      = 8'h02;
    localparam int         SPI_ADDR_FIELD = 24;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } state_t;

    // Bits per frame: opcode + address field + data.
    function automatic int nbits(input int data_width);
        return 8 + SPI_ADDR_FIELD + data_width;
    endfunction

endpackage

// File: rtl/mram_spi_frame_gen_if.sv
// SPI pin bundle between the frame generator and the MRAM device.
// Signals: spi_cs_n (chip select, active low), spi_sck (idles low),
//          spi_mosi (controller to device), spi_miso (device to controller).
// Modports: master = frame generator side, slave = device/model side.
interface mram_spi_frame_gen_if;
    logic spi_cs_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_cs_n, output spi_sck, output spi_mosi, input spi_miso);
    modport slave  (input spi_cs_n, input spi_sck, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator.
// Ports: clk/rst (sync, active high); en runs the clock, clearing it low
//        when deasserted; sck is the SPI clock; rise/fall are one-cycle
//        strobes asserted in the cycle before sck goes high/low.
// Each half-period lasts CLK_DIV clk cycles; the first half after enable is low.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          term;

    assign term = (cnt == CW'(CLK_DIV - 1));
    assign rise = en && term && !sck;
    assign fall = en && term && sck;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (term) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mram_spi_frame_gen.sv
// MRAM SPI frame generator.
// Deserialises a serial address stream (MSB first, one bit per
// addr_bit_valid), and on an accepted start drives one SPI mode-0 frame:
// opcode, zero-padded 24-bit address, then data (write data out, or read
// data captured from spi_miso).
// Ports: clk/rst (sync, active high); addr_bit_in/addr_bit_valid serial
//        address; start/rw/wr_data request; rd_data/rd_valid read result;
//        busy/done/start_err status; state_dbg current FSM state;
//        spi SPI pin bundle (master side).
module mram_spi_frame_gen #(
    parameter int         ADDR_WIDTH = 20,
    parameter int         DATA_WIDTH = 8,
    parameter int         CLK_DIV    = 2,
    parameter logic [7:0] OPC_READ   = mram_spi_pkg::OPC_READ,
    parameter logic [7:0] OPC_WRITE  = mram_spi_pkg::OPC_WRITE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  addr_bit_in,
    input  logic                  addr_bit_valid,
    input  logic                  start,
    input  logic                  rw,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err,
    output mram_spi_pkg::state_t  state_dbg,
    mram_spi_frame_gen_if.master  spi
);

    import mram_spi_pkg::*;

    localparam int NB  = nbits(DATA_WIDTH);
    localparam int BCW = $clog2(NB);
    localparam int ACW = $clog2(ADDR_WIDTH + 1);
    localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [ACW-1:0]        addr_cnt;
    logic [NB-1:0]         frame_sr;
    logic                  frame_rw;
    logic [BCW-1:0]        bit_cnt;
    logic [CW-1:0]         tmr;
    logic [DATA_WIDTH-1:0] rd_sr;
    logic                  cs_n, mosi;
    logic                  sck, sck_rise, sck_fall;
    logic                  addr_full, accept, tmr_last, last_bit;

    assign addr_full = (addr_cnt == ACW'(ADDR_WIDTH));
    assign accept    = start && (state == IDLE) && addr_full;
    assign tmr_last  = (tmr == CW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == BCW'(NB - 1));

    assign state_dbg    = state;
    assign spi.spi_cs_n = cs_n;
    assign spi.spi_sck  = sck;
    assign spi.spi_mosi = mosi;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == SHIFT),
        .sck  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept)               next_state = CS_SETUP;
            CS_SETUP: if (tmr_last)             next_state = SHIFT;
            SHIFT:    if (sck_fall && last_bit) next_state = CS_HOLD;
            CS_HOLD:  if (tmr_last)             next_state = DONE;
            DONE:                               next_state = IDLE;
            default:                            next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_sr   <= '0;
            addr_cnt  <= '0;
            frame_sr  <= '0;
            frame_rw  <= 1'b0;
            bit_cnt   <= '0;
            tmr       <= '0;
            rd_sr     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            start_err <= start && !accept;
            done      <= (state == DONE);
            rd_valid  <= (state == DONE) && !frame_rw;
            if (state == DONE && !frame_rw) rd_data <= rd_sr;

            // Collector runs in every state; a bit arriving with the
            // accepting start belongs to the next address.
            if (addr_bit_valid) addr_sr <= {addr_sr[ADDR_WIDTH-2:0], addr_bit_in};
            if (accept)
                addr_cnt <= addr_bit_valid ? ACW'(1) : '0;
            else if (addr_bit_valid && !addr_full)
                addr_cnt <= addr_cnt + 1'b1;

            // Setup/hold timer restarts on every state change.
            tmr <= (state != next_state) ? '0 : tmr + 1'b1;

            if (accept) begin
                frame_sr <= {rw ? OPC_WRITE : OPC_READ,
                             SPI_ADDR_FIELD'(addr_sr),
                             rw ? wr_data : '0};
                frame_rw <= rw;
                bit_cnt  <= '0;
                busy     <= 1'b1;
                cs_n     <= 1'b0;
            end

            // First bit is presented as the first SCK-low phase begins.
            if (state == CS_SETUP && next_state == SHIFT) mosi <= frame_sr[NB-1];

            if (state == SHIFT && sck_fall) begin
                if (last_bit) begin
                    mosi <= 1'b0;
                end else begin
                    frame_sr <= {frame_sr[NB-2:0], 1'b0};
                    mosi     <= frame_sr[NB-2];
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end

            if (state == SHIFT && sck_rise && bit_cnt >= BCW'(NB - DATA_WIDTH))
                rd_sr <= {rd_sr[DATA_WIDTH-2:0], spi.spi_miso};

            if (state == DONE) begin
                busy <= 1'b0;
                cs_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mram_spi_frame_gen.sv
module tb_mram_spi_frame_gen;
    import mram_spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       addr_bit_in = 1'b0;
    logic       addr_bit_valid = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b, busy_a, busy_b, done_a, done_b;
    logic       start_err_a, start_err_b;
    state_t     state_a, state_b;

    int         vecs = 0;
    int         errs = 0;

    mram_spi_frame_gen_if bus_a ();
    mram_spi_frame_gen_if bus_b ();

    mram_spi_frame_gen #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .addr_bit_in(addr_bit_in), .addr_bit_valid(addr_bit_valid),
        .start(start), .rw(rw), .wr_data(wr_data), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .busy(busy_a), .done(done_a), .start_err(start_err_a), .state_dbg(state_a), .spi(bus_a)
    );

    mram_spi_frame_gen #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .addr_bit_in(addr_bit_in), .addr_bit_valid(addr_bit_valid),
        .start(start), .rw(rw), .wr_data(wr_data), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .busy(busy_b), .done(done_b), .start_err(start_err_b), .state_dbg(state_b), .spi(bus_b)
    );

    always #5 clk = ~clk;

    // SPI device model: records MOSI on each SCK rise, serves miso_byte in the data phase.
    logic [39:0] cap_a = '0, cap_b = '0;
    int          rises_a = 0;
    logic [7:0]  miso_byte = 8'h00;
    logic        miso_a = 1'b0;
    logic [2:0]  mi;

    assign bus_a.spi_miso = miso_a;
    assign bus_b.spi_miso = 1'b0;

    always @(posedge bus_a.spi_sck or negedge bus_a.spi_cs_n) begin
        if (bus_a.spi_sck) begin
            rises_a = rises_a + 1;
            cap_a   = {cap_a[38:0], bus_a.spi_mosi};
        end else begin
            rises_a = 0;
            cap_a   = '0;
        end
    end

    always @(negedge bus_a.spi_sck) begin
        if (rises_a >= 32 && rises_a < 40) begin
            mi     = 3'(39 - rises_a);
            miso_a = miso_byte[mi];
        end else begin
            miso_a = 1'b0;
        end
    end

    always @(posedge bus_b.spi_sck or negedge bus_b.spi_cs_n) begin
        if (bus_b.spi_sck) cap_b = {cap_b[38:0], bus_b.spi_mosi};
        else               cap_b = '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        addr_bit_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic feed_addr(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            addr_bit_in    = val[i];
            addr_bit_valid = 1'b1;
            tick();
        end
        addr_bit_valid = 1'b0;
    endtask

    // Called in cycle 1 of a frame; returns the cycle number where done is seen.
    task automatic wait_done(output int cyc);
        for (cyc = 1; cyc < 400; cyc++) begin
            if (done_a) break;
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (rd_data_a !== 8'h00)    begin errs++; $display("FAIL reset_rd_data got %h exp 00", rd_data_a); end
        vecs++; if (rd_valid_a !== 1'b0)    begin errs++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid_a); end
        vecs++; if (busy_a !== 1'b0)        begin errs++; $display("FAIL reset_busy got %b exp 0", busy_a); end
        vecs++; if (done_a !== 1'b0)        begin errs++; $display("FAIL reset_done got %b exp 0", done_a); end
        vecs++; if (start_err_a !== 1'b0)   begin errs++; $display("FAIL reset_start_err got %b exp 0", start_err_a); end
        vecs++; if (bus_a.spi_cs_n !== 1'b1) begin errs++; $display("FAIL reset_cs_n got %b exp 1", bus_a.spi_cs_n); end
        vecs++; if (bus_a.spi_sck !== 1'b0)  begin errs++; $display("FAIL reset_sck got %b exp 0", bus_a.spi_sck); end
        vecs++; if (bus_a.spi_mosi !== 1'b0) begin errs++; $display("FAIL reset_mosi got %b exp 0", bus_a.spi_mosi); end
        vecs++; if (state_a !== IDLE)        begin errs++; $display("FAIL reset_state got %0d exp IDLE", state_a); end
        // Start with an empty collector must be rejected.
        start = 1'b1; tick(); start = 1'b0;
        vecs++; if (start_err_a !== 1'b1)   begin errs++; $display("FAIL reset_empty_start got %b exp 1", start_err_a); end
    endtask

    task automatic test_write();
        int cyc;
        feed_addr(32'h000ABCDE, 20);
        rw = 1'b1; wr_data = 8'h5A; start = 1'b1;
        tick(); start = 1'b0;
        vecs++; if (bus_a.spi_cs_n !== 1'b0 || busy_a !== 1'b1)
            begin errs++; $display("FAIL write_cycle1 got cs_n=%b busy=%b exp cs_n=0 busy=1", bus_a.spi_cs_n, busy_a); end
        wait_done(cyc);
        vecs++; if (cyc != 166) begin errs++; $display("FAIL write_done_cycle got %0d exp 166", cyc); end
        vecs++; if (cap_a !== 40'h020ABCDE5A) begin errs++; $display("FAIL write_mosi got %h exp 020abcde5a", cap_a); end
        vecs++; if (rises_a != 40) begin errs++; $display("FAIL write_sck_rises got %0d exp 40", rises_a); end
        vecs++; if (bus_a.spi_cs_n !== 1'b1 || busy_a !== 1'b0 || rd_valid_a !== 1'b0)
            begin errs++; $display("FAIL write_done_state got cs_n=%b busy=%b rd_valid=%b exp 1 0 0", bus_a.spi_cs_n, busy_a, rd_valid_a); end
        tick();
        vecs++; if (done_a !== 1'b0) begin errs++; $display("FAIL write_done_pulse got %b exp 0", done_a); end
    endtask

    task automatic test_read();
        int cyc;
        miso_byte = 8'hC3;
        feed_addr(32'h00000001, 20);
        rw = 1'b0; wr_data = 8'hFF; start = 1'b1;
        tick(); start = 1'b0;
        wait_done(cyc);
        vecs++; if (cyc != 166) begin errs++; $display("FAIL read_done_cycle got %0d exp 166", cyc); end
        vecs++; if (rd_valid_a !== 1'b1) begin errs++; $display("FAIL read_rd_valid got %b exp 1", rd_valid_a); end
        vecs++; if (rd_data_a !== 8'hC3) begin errs++; $display("FAIL read_rd_data got %h exp c3", rd_data_a); end
        vecs++; if (cap_a !== 40'h0300000100) begin errs++; $display("FAIL read_mosi got %h exp 0300000100", cap_a); end
        tick();
        vecs++; if (rd_valid_a !== 1'b0 || rd_data_a !== 8'hC3)
            begin errs++; $display("FAIL read_hold got rd_valid=%b rd_data=%h exp 0 c3", rd_valid_a, rd_data_a); end
    endtask

    task automatic test_short_addr();
        int cyc;
        feed_addr(32'h00055555, 19);
        rw = 1'b1; wr_data = 8'h00; start = 1'b1;
        tick(); start = 1'b0;
        vecs++; if (start_err_a !== 1'b1 || bus_a.spi_cs_n !== 1'b1 || busy_a !== 1'b0)
            begin errs++; $display("FAIL short_reject got err=%b cs_n=%b busy=%b exp 1 1 0", start_err_a, bus_a.spi_cs_n, busy_a); end
        tick();
        vecs++; if (start_err_a !== 1'b0) begin errs++; $display("FAIL short_err_pulse got %b exp 0", start_err_a); end
        feed_addr(32'h00000001, 1);
        start = 1'b1;
        tick(); start = 1'b0;
        vecs++; if (start_err_a !== 1'b0 || bus_a.spi_cs_n !== 1'b0)
            begin errs++; $display("FAIL short_accept got err=%b cs_n=%b exp 0 0", start_err_a, bus_a.spi_cs_n); end
        wait_done(cyc);
        vecs++; if (cap_a !== 40'h020AAAAB00) begin errs++; $display("FAIL short_mosi got %h exp 020aaaab00", cap_a); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic got_err = 1'b0;
        logic [19:0] new_addr = 20'h2BEEF;
        feed_addr(32'h00011111, 20);
        rw = 1'b1; wr_data = 8'hA5; start = 1'b1;
        tick(); start = 1'b0;
        for (cyc = 1; cyc < 400; cyc++) begin
            if (cyc == 11) got_err = start_err_a;
            if (state_a == DONE) break;
            start = (cyc == 10);
            addr_bit_valid = (cyc >= 20 && cyc < 40);
            if (cyc >= 20 && cyc < 40) addr_bit_in = new_addr[5'(39 - cyc)];
            tick();
        end
        start = 1'b0; addr_bit_valid = 1'b0;
        vecs++; if (got_err !== 1'b1) begin errs++; $display("FAIL b2b_busy_err got %b exp 1", got_err); end
        vecs++; if (cyc != 165) begin errs++; $display("FAIL b2b_done_state_cycle got %0d exp 165", cyc); end
        // Start during the DONE cycle is rejected.
        start = 1'b1;
        tick();
        vecs++; if (start_err_a !== 1'b1 || done_a !== 1'b1)
            begin errs++; $display("FAIL b2b_done_reject got err=%b done=%b exp 1 1", start_err_a, done_a); end
        vecs++; if (cap_a !== 40'h02011111A5) begin errs++; $display("FAIL b2b_mosi1 got %h exp 02011111a5", cap_a); end
        // Start in the following IDLE cycle is accepted.
        wr_data = 8'h3C;
        tick(); start = 1'b0;
        vecs++; if (start_err_a !== 1'b0 || busy_a !== 1'b1)
            begin errs++; $display("FAIL b2b_accept got err=%b busy=%b exp 0 1", start_err_a, busy_a); end
        wait_done(cyc);
        vecs++; if (cyc != 166) begin errs++; $display("FAIL b2b_done_cycle got %0d exp 166", cyc); end
        vecs++; if (cap_a !== 40'h0202BEEF3C) begin errs++; $display("FAIL b2b_mosi2 got %h exp 0202beef3c", cap_a); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        feed_addr(32'h000ABCDE, 20);
        rw = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if (bus_a.spi_cs_n !== 1'b1 || bus_a.spi_sck !== 1'b0 || busy_a !== 1'b0 || state_a !== IDLE)
            begin errs++; $display("FAIL rstmid_state got cs_n=%b sck=%b busy=%b st=%0d exp 1 0 0 IDLE",
                                   bus_a.spi_cs_n, bus_a.spi_sck, busy_a, state_a); end
        vecs++; if (rd_data_a !== 8'h00) begin errs++; $display("FAIL rstmid_rd_data got %h exp 00", rd_data_a); end
        for (int i = 0; i < 200; i++) begin
            if (done_a || rd_valid_a || !bus_a.spi_cs_n) seen = 1'b1;
            tick();
        end
        vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL rstmid_no_done got %b exp 0", seen); end
        start = 1'b1;
        tick(); start = 1'b0;
        vecs++; if (start_err_a !== 1'b1) begin errs++; $display("FAIL rstmid_collector got %b exp 1", start_err_a); end
    endtask

    task automatic test_extra_bits();
        int cyc;
        feed_addr(32'h01FABCDE, 25);
        rw = 1'b1; wr_data = 8'h77; start = 1'b1;
        tick(); start = 1'b0;
        wait_done(cyc);
        vecs++; if (cap_a !== 40'h020ABCDE77) begin errs++; $display("FAIL extra_mosi got %h exp 020abcde77", cap_a); end
    endtask

    task automatic test_clkdiv1();
        int cyc_a = 0, cyc_b = 0;
        do_reset();
        feed_addr(32'h000ABCDE, 20);
        rw = 1'b1; wr_data = 8'h5A; start = 1'b1;
        tick(); start = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (done_b && cyc_b == 0) cyc_b = cyc;
            if (done_a) begin cyc_a = cyc; break; end
            if (cyc_b != 0 && cyc == cyc_b + 1)
                begin vecs++; if (cap_b !== 40'h020ABCDE5A) begin errs++; $display("FAIL div1_mosi got %h exp 020abcde5a", cap_b); end end
            tick();
        end
        vecs++; if (cyc_b != 84)  begin errs++; $display("FAIL div1_done_cycle got %0d exp 84", cyc_b); end
        vecs++; if (cyc_a != 166) begin errs++; $display("FAIL div2_done_cycle got %0d exp 166", cyc_a); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_short_addr();
        test_back_to_back();
        test_reset_mid();
        test_extra_bits();
        test_clkdiv1();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
